// File: rtl/cic_pkg.sv
// Shared constants, FSM state type and rate helper for the CIC decimator control path.
package cic_pkg;

    localparam int N_STAGES = 4;
    localparam int RATE_LOG = 7;
    localparam int MAX_RATE = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECONF = 2'd1,
        ST_PRIME  = 2'd2,
        ST_RUN    = 2'd3
    } cic_sched_state_t;

    function automatic logic rate_is_legal(input logic [7:0] rate);
        return (rate != 8'd0) && (rate <= 8'(MAX_RATE));
    endfunction

endpackage

// File: rtl/cic_strobe_delay.sv
// Fixed-latency token shift register; a token entering on token_in leaves LAT cycles later.
// flush synchronously empties every stage.
module cic_strobe_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic token_in,
    output logic token_out
);

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        logic tap_reg;
        logic tap_in;

        if (gi == 0) begin : g_head
            assign tap_in = token_in;
        end else begin : g_tail
            assign tap_in = g_stage[gi-1].tap_reg;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tap_reg <= 1'b0;
            end else if (flush) begin
                tap_reg <= 1'b0;
            end else begin
                tap_reg <= tap_in;
            end
        end
    end

    assign token_out = g_stage[LAT-1].tap_reg;

endmodule

// File: rtl/cic_dec_scheduler.sv
// Sequencer for cic_decimator: rate reconfiguration, warm-up discard and a one-entry output register.
// Optional sticky overrun detection is built when CIC_SCHED_OVERRUN_EN is defined.
module cic_dec_scheduler
    import cic_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int DEFAULT_RATE = 16,
    parameter int OUT_LAT      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_enable,
    input  logic [7:0]       rate_req,
    input  logic             rate_load,
    output logic             rate_err,
    output logic             busy,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             cic_enable,
    output logic [7:0]       cic_rate,
    output logic [WIDTH-1:0] cic_data_in,
    output logic             cic_stb_in,
    output logic             cic_stb_out,
    input  logic [WIDTH-1:0] cic_data_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    cic_sched_state_t     state_reg;
    cic_sched_state_t     state_next;
    logic                 rc_cnt_reg;
    logic [2:0]           warm_cnt_reg;
    logic [RATE_LOG-1:0]  dcnt_reg;
    logic [7:0]           rate_reg;
    logic                 rate_err_reg;
    logic [WIDTH-1:0]     data_in_reg;
    logic                 stb_in_reg;
    logic                 stb_out_reg;
    logic [WIDTH-1:0]     out_data_reg;
    logic                 out_valid_reg;

    logic load_ok;
    logic load_bad;
    logic token_exit;
    logic flush;
    logic accept_win;
    logic capture;
    logic dcnt_last;

    assign load_ok  = rate_load && rate_is_legal(rate_req);
    assign load_bad = rate_load && !rate_is_legal(rate_req);

    always_comb begin
        state_next = state_reg;
        if (!ctrl_enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_RECONF;
                end
                ST_RECONF: begin
                    if (!load_ok && rc_cnt_reg) begin
                        state_next = ST_PRIME;
                    end
                end
                ST_PRIME: begin
                    if (load_ok) begin
                        state_next = ST_RECONF;
                    end else if (token_exit && (warm_cnt_reg == 3'(N_STAGES - 1))) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load_ok) begin
                        state_next = ST_RECONF;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Inputs are only passed through while both this and the next cycle keep the decimator running,
    // so nothing leaks into the decimator across a reconfiguration edge.
    assign accept_win = ((state_reg == ST_PRIME) || (state_reg == ST_RUN)) &&
                        ((state_next == ST_PRIME) || (state_next == ST_RUN));
    assign flush      = (state_next == ST_IDLE) || (state_next == ST_RECONF);
    assign capture    = token_exit && (state_reg == ST_RUN) && (state_next == ST_RUN);
    assign dcnt_last  = ({1'b0, dcnt_reg} == (rate_reg - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rc_cnt_reg   <= 1'b0;
            warm_cnt_reg <= '0;
            dcnt_reg     <= '0;
            rate_reg     <= 8'(DEFAULT_RATE);
            rate_err_reg <= 1'b0;
            data_in_reg  <= '0;
            stb_in_reg   <= 1'b0;
            stb_out_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rc_cnt_reg   <= (state_reg == ST_RECONF) && (state_next == ST_RECONF) && !load_ok;
            rate_err_reg <= load_bad;
            if (load_ok) begin
                rate_reg <= rate_req;
            end

            if (accept_win) begin
                data_in_reg <= in_data;
                stb_in_reg  <= in_valid;
            end else begin
                stb_in_reg  <= 1'b0;
            end

            // dcnt holds the count of strobes already issued, so the output strobe can be
            // registered alongside the input strobe it belongs to.
            stb_out_reg <= accept_win && in_valid && dcnt_last;
            if (!accept_win) begin
                dcnt_reg <= '0;
            end else if (in_valid) begin
                dcnt_reg <= dcnt_last ? '0 : dcnt_reg + 1'b1;
            end

            if ((state_reg != ST_PRIME) || (state_next != ST_PRIME)) begin
                warm_cnt_reg <= '0;
            end else if (token_exit) begin
                warm_cnt_reg <= warm_cnt_reg + 3'd1;
            end
        end
    end

    cic_strobe_delay #(
        .LAT(OUT_LAT)
    ) u_strobe_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .token_in (stb_out_reg),
        .token_out(token_exit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (capture) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= cic_data_out;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

`ifdef CIC_SCHED_OVERRUN_EN
    logic overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_reg <= 1'b0;
        end else if (load_ok || !ctrl_enable) begin
            overrun_reg <= 1'b0;
        end else if (capture && out_valid_reg && !out_ready) begin
            overrun_reg <= 1'b1;
        end
    end

    assign overrun = overrun_reg;
`else
    assign overrun = 1'b0;
`endif

    assign rate_err    = rate_err_reg;
    assign busy        = (state_reg != ST_RUN);
    assign cic_enable  = (state_reg == ST_PRIME) || (state_reg == ST_RUN);
    assign cic_rate    = rate_reg;
    assign cic_data_in = data_in_reg;
    assign cic_stb_in  = stb_in_reg;
    assign cic_stb_out = stb_out_reg;
    assign out_data    = out_data_reg;
    assign out_valid   = out_valid_reg;

endmodule

// File: tb/tb_cic_dec_scheduler.sv
// Self-checking bench for cic_dec_scheduler: cycle model of the scheduler plus a scoreboard of
// expected decimated samples derived from the driven stimulus.
`timescale 1ns/1ps
module tb_cic_dec_scheduler;

    localparam int WIDTH   = 16;
    localparam int OUT_LAT = 2;
    localparam int NEVER   = 32'h7fffffff;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ctrl_enable;
    logic [7:0]       rate_req;
    logic             rate_load;
    logic             rate_err;
    logic             busy;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             cic_enable;
    logic [7:0]       cic_rate;
    logic [WIDTH-1:0] cic_data_in;
    logic             cic_stb_in;
    logic             cic_stb_out;
    logic [WIDTH-1:0] cic_data_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             overrun;

    always #5 clk = ~clk;

    cic_dec_scheduler #(
        .WIDTH       (WIDTH),
        .DEFAULT_RATE(16),
        .OUT_LAT     (OUT_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ctrl_enable (ctrl_enable),
        .rate_req    (rate_req),
        .rate_load   (rate_load),
        .rate_err    (rate_err),
        .busy        (busy),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .cic_enable  (cic_enable),
        .cic_rate    (cic_rate),
        .cic_data_in (cic_data_in),
        .cic_stb_in  (cic_stb_in),
        .cic_stb_out (cic_stb_out),
        .cic_data_out(cic_data_out),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun)
    );

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] rq;
        logic       exp_err;
        logic [7:0] exp_rate;
    } load_vec_t;

    exp_t        sb[$];
    load_vec_t   lv[6];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    // reference model state
    bit          idle_m = 1'b1;
    int          prime_from = NEVER;
    int          run_from = NEVER;
    int          acc = 0;
    int          rate_m = 16;
    bit          ov_m = 1'b0;
    bit          ovr_m = 1'b0;
    logic [15:0] d_m = '0;
    bit          last_stb = 1'b0;
    int          first_valid = -1;

    function automatic logic [15:0] dec_val(input int c);
        return 16'(c * 37 + 32'h1234);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        cic_data_out = dec_val(cyc);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cic_rate"}, 32'(cic_rate), 32'd16);
        check({tag, "_cic_enable"}, 32'(cic_enable), 32'd0);
        check({tag, "_cic_stb_in"}, 32'(cic_stb_in), 32'd0);
        check({tag, "_cic_stb_out"}, 32'(cic_stb_out), 32'd0);
        check({tag, "_cic_data_in"}, 32'(cic_data_in), 32'd0);
        check({tag, "_out_data"}, 32'(out_data), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rate_err"}, 32'(rate_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic reset_model();
        idle_m = 1'b1; prime_from = NEVER; run_from = NEVER; acc = 0; rate_m = 16;
        ov_m = 1'b0; ovr_m = 1'b0; last_stb = 1'b0;
        sb.delete();
    endtask

    // Drive one cycle of inputs, advance the model and compare every output on the next cycle.
    task automatic step(input logic iv, input logic en, input logic ld, input logic [7:0] rq,
                        input logic rdy);
        bit          legal, kill, accepted, exp_stb, exp_err, rdy_prev;
        logic [15:0] dv;
        exp_t        e;
        legal    = ld && (rq != 8'd0) && (rq <= 8'd128);
        exp_err  = ld && !legal;
        kill     = !en || (!idle_m && legal);
        accepted = iv && !kill && (cyc >= prime_from);
        dv       = 16'($urandom);
        in_valid = iv; in_data = dv; ctrl_enable = en; rate_load = ld; rate_req = rq; out_ready = rdy;
        exp_stb  = 1'b0;
        if (accepted) begin
            acc++;
            if (acc % rate_m == 0) begin
                exp_stb = 1'b1;
                if (acc == 4 * rate_m) run_from = cyc + 4;
                if (acc >= 5 * rate_m) begin
                    e.cyc  = cyc + 4;
                    e.data = dec_val(cyc + 3);
                    sb.push_back(e);
                end
            end
        end
        if (legal) rate_m = int'(rq);
        if (legal || !en) ovr_m = 1'b0;
        if (!en) begin
            idle_m = 1'b1; prime_from = NEVER; run_from = NEVER; acc = 0; sb.delete();
        end else if (idle_m || legal) begin
            idle_m = 1'b0; prime_from = cyc + 3; run_from = NEVER; acc = 0; sb.delete();
        end
        rdy_prev = rdy;
        last_stb = exp_stb;
        tick();
        check("cic_stb_in", 32'(cic_stb_in), 32'(accepted));
        check("cic_stb_out", 32'(cic_stb_out), 32'(exp_stb));
        if (accepted) check("cic_data_in", 32'(cic_data_in), 32'(dv));
        check("cic_enable", 32'(cic_enable), 32'(cyc >= prime_from));
        check("busy", 32'(busy), 32'(cyc < run_from));
        check("cic_rate", 32'(cic_rate), 32'(rate_m));
        check("rate_err", 32'(rate_err), 32'(exp_err));
        if (kill) begin
            ov_m = 1'b0;
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            if (ov_m && !rdy_prev) ovr_m = 1'b1;
            ov_m = 1'b1;
            d_m  = sb[0].data;
            void'(sb.pop_front());
            if (first_valid < 0) first_valid = cyc;
        end else if (ov_m && rdy_prev) begin
            ov_m = 1'b0;
        end
        check("out_valid", 32'(out_valid), 32'(ov_m));
        if (ov_m) check("out_data", 32'(out_data), 32'(d_m));
`ifdef CIC_SCHED_OVERRUN_EN
        check("overrun", 32'(overrun), 32'(ovr_m));
`else
        check("overrun", 32'(overrun), 32'd0);
`endif
    endtask

    initial begin
        int s;
        int en_low;
        bit found;

        lv[0] = '{8'd0,   1'b1, 8'd16};
        lv[1] = '{8'd129, 1'b1, 8'd16};
        lv[2] = '{8'd255, 1'b1, 8'd16};
        lv[3] = '{8'd128, 1'b0, 8'd128};
        lv[4] = '{8'd1,   1'b0, 8'd1};
        lv[5] = '{8'd16,  1'b0, 8'd16};

        rst_n = 1'b0; ctrl_enable = 1'b0; rate_load = 1'b0; rate_req = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1; cic_data_out = dec_val(0);
        repeat (3) tick();
        check_reset("reset");
        rst_n = 1'b1;

        // rate load table applied in IDLE
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, lv[i].rq, 1'b1);
            check("tbl_rate_err", 32'(rate_err), 32'(lv[i].exp_err));
            check("tbl_cic_rate", 32'(cic_rate), 32'(lv[i].exp_rate));
            step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
            check("tbl_err_clear", 32'(rate_err), 32'd0);
        end

        // default rate 16, continuous input
        s = cyc; first_valid = -1;
        repeat (16 * 9 + 1) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        check("first_valid_r16", 32'(first_valid), 32'(s + 6 + 5 * 16));
        check("run_busy_low", 32'(busy), 32'd0);

        // reconfigure to rate 4 while running
        s = cyc; first_valid = -1; en_low = 0;
        step(1'b1, 1'b1, 1'b1, 8'd4, 1'b1);
        if (!cic_enable) en_low++;
        repeat (60) begin
            step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
            if (!cic_enable) en_low++;
        end
        check("reconf_enable_low_cycles", 32'(en_low), 32'd2);
        check("first_valid_r4", 32'(first_valid), 32'(s + 6 + 5 * 4));

        // rate 1, input strobe every other cycle
        step(1'b0, 1'b1, 1'b1, 8'd1, 1'b1);
        for (int i = 0; i < 60; i++) step(1'(i % 2 == 0), 1'b1, 1'b0, 8'd0, 1'b1);

        // overrun: rate 4, hold off the consumer across three captures
        step(1'b1, 1'b1, 1'b1, 8'd4, 1'b1);
        repeat (50) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        repeat (12) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
`ifdef CIC_SCHED_OVERRUN_EN
        check("overrun_set", 32'(overrun), 32'd1);
`else
        check("overrun_set", 32'(overrun), 32'd0);
`endif
        repeat (4) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd8, 1'b1);
        check("overrun_cleared_by_load", 32'(overrun), 32'd0);

        // rate 8, drop ctrl_enable while a token is in flight
        repeat (60) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
            found = last_stb;
        end
        check("drop_token_found", 32'(found), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        check("drop_busy", 32'(busy), 32'd1);
        check("drop_enable", 32'(cic_enable), 32'd0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 8'd0, 1'b1);
        s = cyc; first_valid = -1;
        repeat (8 * 6 + 8) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        check("first_valid_after_drop", 32'(first_valid), 32'(s + 6 + 5 * 8));

        // random traffic at rate 3 with a sporadic consumer
        step(1'b1, 1'b1, 1'b1, 8'd3, 1'b1);
        repeat (300) step(1'($urandom_range(0, 3) != 0), 1'b1, 1'b0, 8'd0,
                          1'($urandom_range(0, 2) != 0));

        // asynchronous reset in the middle of a cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        tick();
        check_reset("async_reset_hold");
        rst_n = 1'b1;
        reset_model();
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        s = cyc; first_valid = -1;
        repeat (16 * 6 + 8) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
        check("first_valid_after_reset", 32'(first_valid), 32'(s + 6 + 5 * 16));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
